fp_div_iter: RTL
================

# fp_div_iter

Parametrised iterative floating-point divider for the FPU datapath, generalising the bfloat16 divider to any exponent/mantissa split. It computes one quotient bit per cycle and handles IEEE special cases with a one-cycle fast path. Rounding is round-to-nearest-even by default. It replaces the fixed-width divider behind the FPU issue logic, keeping the `start`/`busy`/`valid` handshake.

## Interface
- `EXP_W`, 8: exponent width; `BIAS = 2^(EXP_W-1)-1`.
- `MAN_W`, 7: stored mantissa width (defaults give bfloat16); `W = 1+EXP_W+MAN_W`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only when `busy`=0.
- `opA`, `opB` in W: dividend and divisor, `{sign, exp, man}`.
- `quotient` out W: registered result; holds until the next result.
- `valid` out 1: one-cycle pulse when `quotient` and the flags update.
- `busy` out 1: an operation is in flight.
- `overflow`, `underflow`, `inexact`, `invalid`, `div_by_zero` out 1 each: sticky-free per-result flags, updated with `valid`.

## Operation
- **Accept:** `start`=1 with `busy`=0 captures the operands. `start` while `busy`=1 is ignored. No queueing.
- **Operand classes:** exp=0 is zero (subnormals flushed to zero). Exp all-ones with man=0 is infinity; with man≠0 it is NaN.
- **Special-case priority**, sign `sA^sB` unless NaN:
  - any NaN, 0/0, or inf/inf → canonical qNaN (sign 0, exp all-ones, man MSB 1, rest 0), `invalid`.
  - finite nonzero/0 → ±inf, `div_by_zero`.
  - inf/finite → ±inf, no flags.
  - finite/inf or 0/nonzero → ±0, no flags.
- **Normal path, state machine:**
  - IDLE → DIV: on accepted normal `start`.
  - DIV: restoring division of `{1,mA}·2^(MAN_W+2)` by `{1,mB}`, MAN_W+3 iterations, giving quotient Q[MAN_W+2:0] and remainder R.
  - DIV → RND: after MAN_W+3 iterations.
  - RND → IDLE: registers the outputs.
- **Special path:** IDLE → SPEC → IDLE. SPEC registers the outputs.
- **Exponent:** `E = eA − eB + BIAS`, computed in signed EXP_W+2 bits.
- **Normalise:**
  - If Q MSB = 0: shift Q left 1 and use `E−1`.
  - Take MAN_W+1 significant bits and 1 guard bit.
  - sticky = (any lower Q bit) | (R≠0).
- **Round:** RNE on guard/sticky/LSB. A mantissa carry-out increments E and sets the mantissa to 0.
- **Range:**
  - Final E ≥ 2^EXP_W−1 → ±inf, `overflow`, `inexact`.
  - Final E ≤ 0 → ±0, `underflow`, `inexact`.
- **`inexact`:** guard|sticky on any normal-path result, independent of rounding mode.

## Timing
- **Reset values:** `quotient`=0, all flags 0, `valid`=0, `busy`=0, state IDLE.
- **Reset mid-operation:** aborts with no `valid` and no output change other than the reset values.
- **Cycle numbering:** start accepted at edge 0.
  - `busy`=1 from cycle 1 until the cycle `valid` is high; it is 0 in the `valid` cycle.
  - A new `start` is accepted in the `valid` cycle, so results can issue back-to-back.
- **Normal latency:** `valid` high in cycle MAN_W+5 (12 for bfloat16).
- **Special latency:** `valid` high in cycle 2.
- **Between results:** `valid` is 0 and `quotient`/flags hold.
- **Operands:** may change after acceptance without effect.

## Configuration
- **`FP_DIV_ROUND_EN` defined:** round-to-nearest-even as above.
- **Undefined:** truncate toward zero.
  - No rounding increment, hence no round carry.
  - `inexact`, `overflow` and `underflow` are still reported.
  - Overflow still saturates to ±inf.
  - Latency is unchanged.

## Structure
- **`fpu_pkg`:** state enum (IDLE, SPEC, DIV, RND), operand-class enum (ZERO, NORM, INF, NAN), flag struct, and parametrised qNaN/inf constant functions of EXP_W/MAN_W.
- **Sub-module `fp_mant_div`:** iterative unsigned restoring divider (width MAN_W+1, MAN_W+3 quotient bits) with `load`/`done` strobes and `Q`/`R` outputs. The top level owns classification, exponent, normalise/round and the handshake.

## Test plan
- 0x3F80 / 0x3F80 → 0x3F80, all flags 0, `valid` in cycle 12, `busy` cycles 1–11.
- 0x3F80 / 0x4040 (1/3) → 0x3EAB and `inexact` with `FP_DIV_ROUND_EN`; → 0x3EAA and `inexact` without it.
- 0x3F80 / 0x0000 → 0x7F80, `div_by_zero`, `valid` in cycle 2. 0x0000 / 0x0000 → 0x7FC0, `invalid`.
- 0x7F00 / 0x0080 → 0x7F80, `overflow`+`inexact`. 0x0080 / 0x7F00 → 0x0000, `underflow`+`inexact`.
- Back-to-back starts in `valid` cycles; `start` pulsed mid-DIV is ignored. Sign check: 0xBF80 / 0x4000 → 0xBF00.
- `reset` asserted in cycle 5 of a divide → no `valid`, outputs at reset values; the next start completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the iterative floating-point divider.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SPEC,
    DIV,
    RND
  } state_t;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } cls_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
    logic invalid;
    logic div_by_zero;
  } flags_t;

  // Unsigned infinity pattern {exp all-ones, man 0}, right-aligned in 64 bits.
  function automatic logic [63:0] inf_bits(input int exp_w, input int man_w);
    logic [63:0] e_ones;
    e_ones = (64'd1 << exp_w) - 64'd1;
    return e_ones << man_w;
  endfunction

  // Canonical quiet NaN: sign 0, exp all-ones, only the mantissa MSB set.
  function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
    return inf_bits(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_mant_div.sv
// Iterative unsigned restoring divider: {a} * 2^(NQ-1) / {b}, one quotient
// bit per cycle, MSB first. Both operands carry their hidden 1, so the
// partial remainder always stays below the divisor.
module fp_mant_div
  import fpu_pkg::*;
#(
  parameter int MW = 8,
  parameter int NQ = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [MW-1:0] a,
  input  logic [MW-1:0] b,
  output logic          done,
  output logic [NQ-1:0] q,
  output logic [MW-1:0] r
);

  localparam int CW = $clog2(NQ);
  localparam logic [CW-1:0] LAST = CW'(NQ - 1);

  logic          run;
  logic [CW-1:0] cnt;
  logic [MW-1:0] dvsr;
  logic [MW:0]   trial;
  logic [MW:0]   diff;
  logic          ge;

  // Trial subtraction; the first step compares the dividend unshifted.
  // Since remainder < divisor, diff fits in MW+1 signed bits and its MSB
  // is a reliable borrow.
  always_comb begin
    trial = (cnt == '0) ? {1'b0, r} : {r, 1'b0};
    diff  = trial - {1'b0, dvsr};
    ge    = ~diff[MW];
  end

  // done is high during the cycle whose closing edge produces the last bit.
  assign done = run && (cnt == LAST);

  // Iteration control: start on load, stop after NQ bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
      if (done) run <= 1'b0;
    end
  end

  // Quotient/remainder datapath: shift in one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (load) begin
      r    <= a;
      dvsr <= b;
      q    <= '0;
    end else if (run) begin
      q <= {q[NQ-2:0], ge};
      r <= ge ? diff[MW-1:0] : trial[MW-1:0];
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// Parametrised iterative floating-point divider with a one-cycle special
// case path. Define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise
// results are truncated toward zero.
module fp_div_iter
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [EXP_W+MAN_W:0]     opA,
  input  logic [EXP_W+MAN_W:0]     opB,
  output logic [EXP_W+MAN_W:0]     quotient,
  output logic                     valid,
  output logic                     busy,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     inexact,
  output logic                     invalid,
  output logic                     div_by_zero
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int NQ   = MAN_W + 3;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic [W-1:0]          INF_P  = W'(inf_bits(EXP_W, MAN_W));
  localparam logic [W-1:0]          QNAN   = W'(qnan_bits(EXP_W, MAN_W));
  localparam logic [W-2:0]          INF_M  = INF_P[W-2:0];
  localparam logic signed [EW-1:0]  BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0]  E_OVF  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0]  E_ZERO = '0;
  localparam logic signed [EW-1:0]  ONE_E  = EW'(1);

  state_t state;
  flags_t flg_q;

  cls_t                   cls_a, cls_b;
  logic                   sgn, special;
  logic [W-1:0]           spec_res;
  flags_t                 spec_flg;
  logic signed [EW-1:0]   e_calc;

  logic                   sgn_q;
  logic signed [EW-1:0]   e_q;
  logic [W-1:0]           spec_res_q;
  flags_t                 spec_flg_q;

  logic                   div_load, div_done;
  logic [NQ-1:0]          dq;
  logic [MAN_W:0]         dr;

  logic [NQ-1:0]          qn;
  logic signed [EW-1:0]   e_n, e_f;
  logic                   guard, sticky;
  logic [MAN_W-1:0]       mant, mant_f;
  logic [MAN_W:0]         mant_s;
  logic [W-1:0]           rnd_res;
  flags_t                 rnd_flg;

  function automatic cls_t classify(input logic [W-2:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = x[W-2:MAN_W];
    m = x[MAN_W-1:0];
    if (e == '0)      return ZERO;
    else if (e == '1) return (m == '0) ? INF : NAN;
    else              return NORM;
  endfunction

  // Rounding increment from guard, sticky and result LSB.
  function automatic logic round_inc(input logic g, input logic s, input logic lsb);
`ifdef FP_DIV_ROUND_EN
    return g & (s | lsb);
`else
    return 1'b0 & (g | s | lsb);
`endif
  endfunction

  assign busy        = (state != IDLE);
  assign overflow    = flg_q.overflow;
  assign underflow   = flg_q.underflow;
  assign inexact     = flg_q.inexact;
  assign invalid     = flg_q.invalid;
  assign div_by_zero = flg_q.div_by_zero;

  // Operand classification, special-case result and biased exponent difference.
  always_comb begin
    cls_a    = classify(opA[W-2:0]);
    cls_b    = classify(opB[W-2:0]);
    sgn      = opA[W-1] ^ opB[W-1];
    special  = (cls_a != NORM) || (cls_b != NORM);
    spec_flg = '0;
    if (cls_a == NAN || cls_b == NAN || (cls_a == ZERO && cls_b == ZERO) ||
        (cls_a == INF && cls_b == INF)) begin
      spec_res         = QNAN;
      spec_flg.invalid = 1'b1;
    end else if (cls_a == NORM && cls_b == ZERO) begin
      spec_res             = {sgn, INF_M};
      spec_flg.div_by_zero = 1'b1;
    end else if (cls_a == INF) begin
      spec_res = {sgn, INF_M};
    end else begin
      spec_res = {sgn, {(W-1){1'b0}}};
    end
    e_calc = $signed({2'b00, opA[W-2:MAN_W]}) - $signed({2'b00, opB[W-2:MAN_W]}) + BIAS_E;
  end

  assign div_load = (state == IDLE) && start && !special;

  fp_mant_div #(
    .MW (MAN_W + 1),
    .NQ (NQ)
  ) u_mant_div (
    .clk   (clk),
    .reset (reset),
    .load  (div_load),
    .a     ({1'b1, opA[MAN_W-1:0]}),
    .b     ({1'b1, opB[MAN_W-1:0]}),
    .done  (div_done),
    .q     (dq),
    .r     (dr)
  );

  // Normalise, round and range-check the finished mantissa quotient.
  always_comb begin
    qn  = dq;
    e_n = e_q;
    if (!dq[NQ-1]) begin
      qn  = dq << 1;
      e_n = e_q - ONE_E;
    end
    guard  = qn[1];
    sticky = qn[0] | (dr != '0);
    mant   = qn[NQ-2:2];
    mant_s = {1'b0, mant} + {{MAN_W{1'b0}}, round_inc(guard, sticky, mant[0])};
    e_f    = e_n;
    mant_f = mant_s[MAN_W-1:0];
    if (mant_s[MAN_W]) begin
      e_f    = e_n + ONE_E;
      mant_f = '0;
    end
    rnd_flg         = '0;
    rnd_flg.inexact = guard | sticky;
    if (e_f >= E_OVF) begin
      rnd_res          = {sgn_q, INF_M};
      rnd_flg.overflow = 1'b1;
      rnd_flg.inexact  = 1'b1;
    end else if (e_f <= E_ZERO) begin
      rnd_res           = {sgn_q, {(W-1){1'b0}}};
      rnd_flg.underflow = 1'b1;
      rnd_flg.inexact   = 1'b1;
    end else begin
      rnd_res = {sgn_q, e_f[EXP_W-1:0], mant_f};
    end
  end

  // Capture per-operation context when a request is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sgn_q      <= sgn;
      e_q        <= e_calc;
      spec_res_q <= spec_res;
      spec_flg_q <= spec_flg;
    end
  end

  // Control FSM with registered result, flags and valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= 1'b0;
      quotient <= '0;
      flg_q    <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (start) state <= special ? SPEC : DIV;
        SPEC: begin
          state    <= IDLE;
          valid    <= 1'b1;
          quotient <= spec_res_q;
          flg_q    <= spec_flg_q;
        end
        DIV:  if (div_done) state <= RND;
        RND: begin
          state    <= IDLE;
          valid    <= 1'b1;
          quotient <= rnd_res;
          flg_q    <= rnd_flg;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
